// File: rtl/cf_pkg.sv
// Shared CF datapath definitions: codeword sizing, decoder states, popcount helper.
package cf_pkg;

  localparam int unsigned MAXLEN = 7;
  localparam int unsigned NSYM   = 6;

  typedef logic [MAXLEN-1:0] cw_t;
  typedef logic [2:0]        len_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  // Number of ones in a code mask, i.e. the codeword length.
  function automatic len_t popcount7(input cw_t v);
    len_t n;
    n = '0;
    for (int i = 0; i < int'(MAXLEN); i++) begin
      n = n + len_t'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/huff_decoder_if.sv
// Codebook load, serial bit input and symbol output bundle of the Huffman decoder.
interface huff_decoder_if;
  import cf_pkg::*;

  logic        clear;
  logic        tbl_we;
  logic [2:0]  tbl_addr;
  cw_t         tbl_code;
  cw_t         tbl_mask;
  logic        tbl_done;
  logic        bit_valid;
  logic        bit_in;
  logic        bit_ready;
  logic        sym_valid;
  logic [7:0]  sym;
  logic        sym_ready;
  logic        err;

  modport master (
    output clear, tbl_we, tbl_addr, tbl_code, tbl_mask, tbl_done,
    output bit_valid, bit_in, sym_ready,
    input  bit_ready, sym_valid, sym, err
  );

  modport slave (
    input  clear, tbl_we, tbl_addr, tbl_code, tbl_mask, tbl_done,
    input  bit_valid, bit_in, sym_ready,
    output bit_ready, sym_valid, sym, err
  );

endinterface

// File: rtl/huff_match.sv
// Combinational codebook lookup: finds the entry whose length and masked code equal the
// accumulated bits. Lowest index wins when a malformed table has duplicates.
module huff_match
  import cf_pkg::*;
(
  input  cw_t        acc,
  input  len_t       len,
  input  cw_t        code [NSYM],
  input  cw_t        mask [NSYM],
  output logic       hit,
  output logic [2:0] index
);

  // Scan from the top entry down so a lower matching entry overwrites a higher one.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = int'(NSYM) - 1; i >= 0; i--) begin
      if (mask[i] != '0 && len == popcount7(mask[i]) && (acc & mask[i]) == code[i]) begin
        hit   = 1'b1;
        index = 3'(i + 1);
      end
    end
  end

endmodule

// File: rtl/huff_decoder.sv
// Serial Huffman decoder: holds the codebook, shifts bits MSB-first into an accumulator and
// emits one symbol per completed codeword over a valid/ready output register.
module huff_decoder
  import cf_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  huff_decoder_if.slave  bus
);

  state_t     state_q, state_d;
  cw_t        code_q [NSYM];
  cw_t        code_d [NSYM];
  cw_t        mask_q [NSYM];
  cw_t        mask_d [NSYM];
  cw_t        acc_q, acc_d;
  len_t       len_q, len_d;
  logic [7:0] sym_q, sym_d;
  logic       sym_valid_q, sym_valid_d;
  logic       err_q, err_d;

  cw_t        acc_shift;
  len_t       len_inc;
  logic       hit;
  logic [2:0] hit_idx;
  logic       accept;

  // Match is evaluated on the accumulator as it would look after taking this bit.
  assign acc_shift = {acc_q[MAXLEN-2:0], bus.bit_in};
  assign len_inc   = len_q + 3'd1;

  // Output register is never overwritten: a bit is only taken if the slot is free or draining.
  assign bus.bit_ready = (state_q == RUN) && (!sym_valid_q || bus.sym_ready);
  assign accept        = bus.bit_valid && bus.bit_ready;

  assign bus.sym_valid = sym_valid_q;
  assign bus.sym       = sym_q;
  assign bus.err       = err_q;

  huff_match u_match (
    .acc   (acc_shift),
    .len   (len_inc),
    .code  (code_q),
    .mask  (mask_q),
    .hit   (hit),
    .index (hit_idx)
  );

  // Next-state: table load, bit accumulation, symbol output and error handling.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    mask_d      = mask_q;
    acc_d       = acc_q;
    len_d       = len_q;
    sym_d       = sym_q;
    sym_valid_d = sym_valid_q;
    err_d       = err_q;

    if (bus.clear) begin
      state_d     = IDLE;
      code_d      = '{default: '0};
      mask_d      = '{default: '0};
      acc_d       = '0;
      len_d       = '0;
      sym_d       = '0;
      sym_valid_d = 1'b0;
      err_d       = 1'b0;
    end else begin
      if (sym_valid_q && bus.sym_ready) begin
        sym_valid_d = 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (bus.tbl_we && bus.tbl_addr >= 3'd1 && bus.tbl_addr <= 3'(NSYM)) begin
            code_d[bus.tbl_addr - 3'd1] = bus.tbl_code;
            mask_d[bus.tbl_addr - 3'd1] = bus.tbl_mask;
          end
          if (bus.tbl_done) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (hit) begin
              sym_d       = {5'b0, hit_idx};
              sym_valid_d = 1'b1;
              acc_d       = '0;
              len_d       = '0;
            end else if (len_inc == 3'(MAXLEN)) begin
              state_d = ERR;
              err_d   = 1'b1;
              acc_d   = '0;
              len_d   = '0;
            end else begin
              acc_d = acc_shift;
              len_d = len_inc;
            end
          end
        end
        ERR: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      code_q      <= '{default: '0};
      mask_q      <= '{default: '0};
      acc_q       <= '0;
      len_q       <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      mask_q      <= mask_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: doc/huff_decoder.md
# huff_decoder

Serial Huffman bitstream decoder for the CF datapath, the receive-side counterpart of the symbol-count and code-merge logic. It takes a finished codebook of six entries (symbols 1..6, each with a 7-bit right-aligned code and mask) and a serial bitstream, MSB-first per codeword. It emits one decoded gray symbol per completed codeword. It sits after codebook generation and feeds the symbol-reconstruction stage over a valid/ready handshake.

## Interface
- MAXLEN, 7: maximum codeword length in bits; equals code/mask width.
- NSYM, 6: number of codebook entries (symbols 1..NSYM).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous return to IDLE; invalidates table, accumulator, output register.
- tbl_we  in  1  codebook write strobe; honoured only in IDLE.
- tbl_addr  in  3  symbol index 1..6; 0 and 7 ignored.
- tbl_code  in  7  right-aligned codeword.
- tbl_mask  in  7  right-aligned ones, popcount = code length (1..7).
- tbl_done  in  1  codebook complete; IDLE -> RUN.
- bit_valid  in  1  serial bit present.
- bit_in  in  1  serial bit.
- bit_ready  out  1  decoder accepts bit this cycle.
- sym_valid  out  1  decoded symbol held.
- sym  out  8  decoded symbol, 1..6, zero-extended.
- sym_ready  in  1  downstream takes symbol.
- err  out  1  sticky decode error.

## Operation
- States: IDLE, RUN, ERR. Reset/clear -> IDLE.
- IDLE: tbl_we with tbl_addr 1..6 writes code/mask into entry. tbl_done -> RUN. If tbl_we and tbl_done occur together, the write lands and the transition happens the same cycle. bit_ready=0.
- RUN: a bit is accepted when bit_valid && bit_ready. acc <= {acc[5:0], bit_in}, len <= len+1.
- Match test uses the post-shift acc and len. Entry i matches when len == popcount(mask_i) and (acc & mask_i) == code_i. Unwritten entries (mask 0) never match.
- On match: sym <= i, sym_valid <= 1, acc <= 0, len <= 0. If several entries match (malformed table), the lowest index wins.
- No match and len reaches MAXLEN: -> ERR, err <= 1, acc/len cleared, sym_valid unchanged.
- bit_ready = (state==RUN) && (!sym_valid || sym_ready), so the output register is never overwritten.
- sym_valid clears on sym_valid && sym_ready unless a new match loads the same cycle. In that case it stays 1 with the new sym.
- ERR: bit_ready=0. A pending symbol is still drained. Exit only via clear or reset.
- clear has priority over every other input. The table must be reloaded after clear.

## Timing
- Reset values: bit_ready=0, sym_valid=0, sym=0, err=0. acc, len, all table entries 0. State IDLE.
- Latency: sym_valid rises the cycle after the accepting edge of the codeword's last bit.
- Throughput: one bit per cycle while sym_ready held high, including back-to-back 1-bit codewords.
- bit_ready is combinational from state, sym_valid and sym_ready. There is no combinational path from bit_in.
- err rises the cycle after the 7th unmatched bit is accepted.
- Reset mid-codeword discards the partial codeword and all table contents.

## Structure
- Shared package (cf_pkg): MAXLEN, NSYM, state encoding IDLE/RUN/ERR, and a popcount7 function shared with codebook generation.
- One sub-module, huff_match. It is combinational: acc, len and the six code/mask pairs in; hit and index out with lowest-index priority. It is reused by the encoder check bench.
- The top holds the table, acc/len, FSM and output register.

## Test plan
- Table 1:"1", 2:"01", 3:"001", 4:"0001", 5:"00001", 6:"00000" (code=1 mask=0000001 / 1,0000011 / 1,0000111 / 1,0001111 / 1,0011111 / 0,0011111). Stream 1 01 00000 0001 with sym_ready=1 -> sym 1,2,6,4, each valid one cycle after its last bit.
- Same table, bits every cycle, sym_ready=0 for 5 cycles after first symbol -> bit_ready=0, sym stays 1, no bits lost. Then 2 follows.
- Table with only entries 1,2 written, stream 0000000 -> err=1 after 7th bit, bit_ready=0, sym_valid stays 0.
- Assert reset after bits 0,0 of "001" -> all outputs 0, state IDLE. Reload table, send 001 -> sym 3.
- Duplicate entries 2 and 5 both code "01", stream 01 -> sym=2.
- tbl_we in RUN with new code for entry 1 -> ignored, stream 1 still decodes to 1. After clear, bit_valid is ignored until tbl_done.
